// File: rtl/rrc_pulse_shaper_pkg.sv
// Shared 16-QAM transmit constants and the RRC tap table used by the shaper,
// the upsampler and the golden model.
package rrc_pulse_shaper_pkg;

   localparam int NTAPS         = 33;
   localparam int IW            = 4;
   localparam int CW            = 10;
   localparam int OW            = 12;
   localparam int SPS           = 11;
   localparam int OUT_SHIFT_DEF = 2;

   localparam int TREE_LVLS = $clog2(NTAPS);
   localparam int AW        = IW + CW + TREE_LVLS;
   localparam int LATENCY   = TREE_LVLS + 3;

   typedef logic signed [CW-1:0] coef_t;

   // Symmetric taps, center (index 16) at full scale.
   localparam coef_t RRC_COEF [NTAPS] = '{
      -10'sd20, -10'sd28, -10'sd32, -10'sd30, -10'sd22, -10'sd8,
       10'sd12,  10'sd38,  10'sd70,  10'sd108, 10'sd150, 10'sd196,
       10'sd264, 10'sd330, 10'sd400, 10'sd460, 10'sd511,
       10'sd460, 10'sd400, 10'sd330, 10'sd264, 10'sd196, 10'sd150,
       10'sd108, 10'sd70,  10'sd38,  10'sd12, -10'sd8,  -10'sd22,
      -10'sd30, -10'sd32, -10'sd28, -10'sd20
   };

   // Number of live nodes at a given adder-tree level (level 0 = products).
   function automatic int tree_cnt(input int lv);
      return (NTAPS + (1 << lv) - 1) >> lv;
   endfunction

endpackage

// File: rtl/rrc_fir_channel.sv
// One pipelined RRC FIR channel: delay line, tap multipliers, registered
// pairwise adder tree, round-half-up shift and output saturation.
module rrc_fir_channel
   import rrc_pulse_shaper_pkg::*;
#(
   parameter int OUT_SHIFT = OUT_SHIFT_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic signed [IW-1:0] i_sample,
   output logic signed [OW-1:0] o_shaped
);

   localparam int PW   = IW + CW;
   localparam int RW   = AW + 1;
   localparam int RND  = (1 << OUT_SHIFT) >> 1;
   localparam int HALF = (NTAPS + 1) / 2;
   localparam logic signed [RW-1:0] SAT_HI = RW'((1 << (OW - 1)) - 1);
   localparam logic signed [RW-1:0] SAT_LO = RW'(-(1 << (OW - 1)));

   logic signed [IW-1:0] r_dl   [NTAPS];
   logic signed [PW-1:0] w_prod [NTAPS];
   // Extra column keeps the odd-pass-through index in range on every level.
   logic signed [AW-1:0] r_tree [TREE_LVLS+1][NTAPS+1];
   logic signed [RW-1:0] w_rnd;
   logic signed [RW-1:0] r_rnd;
   logic signed [OW-1:0] w_sat;
   logic signed [OW-1:0] r_out;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NTAPS; k++) r_dl[k] <= '0;
      end else begin
         r_dl[0] <= i_sample;
         for (int k = 1; k < NTAPS; k++) r_dl[k] <= r_dl[k-1];
      end
   end

   always_comb begin
      for (int k = 0; k < NTAPS; k++) w_prod[k] = PW'(r_dl[k]) * PW'(RRC_COEF[k]);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int lv = 0; lv <= TREE_LVLS; lv++)
            for (int j = 0; j <= NTAPS; j++) r_tree[lv][j] <= '0;
      end else begin
         for (int j = 0; j < NTAPS; j++) r_tree[0][j] <= AW'(w_prod[j]);
         for (int lv = 1; lv <= TREE_LVLS; lv++) begin
            for (int j = 0; j < HALF; j++) begin
               if (j < tree_cnt(lv)) begin
                  if (2*j + 1 < tree_cnt(lv - 1))
                     r_tree[lv][j] <= r_tree[lv-1][2*j] + r_tree[lv-1][2*j+1];
                  else
                     r_tree[lv][j] <= r_tree[lv-1][2*j];
               end
            end
         end
      end
   end

   assign w_rnd = (RW'(r_tree[TREE_LVLS][0]) + RW'(RND)) >>> OUT_SHIFT;

   always_comb begin
      w_sat = r_rnd[OW-1:0];
      if (r_rnd > SAT_HI)      w_sat = SAT_HI[OW-1:0];
      else if (r_rnd < SAT_LO) w_sat = SAT_LO[OW-1:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rnd <= '0;
         r_out <= '0;
      end else begin
         r_rnd <= w_rnd;
         r_out <= w_sat;
      end
   end

   assign o_shaped = r_out;

endmodule

// File: rtl/rrc_pulse_shaper.sv
// Dual-channel (I/Q) RRC pulse shaper: two identical FIR channels plus the
// pipeline fill counter that qualifies the outputs.
module rrc_pulse_shaper
   import rrc_pulse_shaper_pkg::*;
#(
   parameter int OUT_SHIFT = OUT_SHIFT_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic signed [IW-1:0] iup,
   input  logic signed [IW-1:0] qup,
   output logic signed [OW-1:0] i_shaped,
   output logic signed [OW-1:0] q_shaped,
   output logic                 out_valid
);

   localparam int CNTW = $clog2(LATENCY + 1);

   logic [CNTW-1:0] r_fill;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                               r_fill <= '0;
      else if (r_fill != CNTW'(LATENCY))       r_fill <= r_fill + 1'b1;
   end

   assign out_valid = (r_fill == CNTW'(LATENCY));

   rrc_fir_channel #(.OUT_SHIFT(OUT_SHIFT)) u_i_ch (
      .clk      (clk),
      .reset    (reset),
      .i_sample (iup),
      .o_shaped (i_shaped)
   );

   rrc_fir_channel #(.OUT_SHIFT(OUT_SHIFT)) u_q_ch (
      .clk      (clk),
      .reset    (reset),
      .i_sample (qup),
      .o_shaped (q_shaped)
   );

endmodule
